// File: rtl/fa_check_pkg.sv
// Shared definitions for the full-adder vector checker: FSM states, vector
// count and the golden full-adder equation.
package fa_check_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StApply = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam int unsigned N_VECTORS = 8;

   // Returns {cout, sum} of a one-bit full adder.
   function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
      logic s;
      logic c;
      s = a ^ b ^ cin;
      c = (a & b) | (a & cin) | (b & cin);
      return {c, s};
   endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Golden combinational full adder that produces the expected response for the
// vector currently being applied.
module fa_ref_model
   import fa_check_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign {cout, sum} = fa_expected(a, b, cin);

endmodule

// File: rtl/fa_vector_checker.sv
// Exhaustive full-adder checker: walks all eight {a,b,cin} vectors, compares the
// DUT response against a golden model and reports error count and first failure.
module fa_vector_checker
   import fa_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CHECK_COUT    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       cin,
   input  logic       sum,
   input  logic       cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail_vec,
   output logic       fail_valid
);

   localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LastVec = 3'(N_VECTORS - 1);
   localparam logic [3:0] MaxErr  = 4'(N_VECTORS);

   state_e     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] abc_q, abc_d;
   logic [3:0] err_q, err_d;
   logic [2:0] ffv_q, ffv_d;
   logic       fv_q, fv_d;
   logic       pass_q, pass_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic exp_sum;
   logic exp_cout;
   logic sample;
   logic mismatch;

   // The model sees the registered stimulus, i.e. exactly what the DUT sees.
   fa_ref_model u_ref (
      .a    (abc_q[2]),
      .b    (abc_q[1]),
      .cin  (abc_q[0]),
      .sum  (exp_sum),
      .cout (exp_cout)
   );

   assign sample   = (state_q == StApply) && (cnt_q == LastCnt);
   assign mismatch = sample &&
                     ((sum != exp_sum) || ((CHECK_COUT != 0) && (cout != exp_cout)));

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      abc_d   = abc_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      fv_d    = fv_q;
      pass_d  = pass_q;
      busy_d  = busy_q;
      done_d  = done_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StApply;
               vec_d   = 3'd0;
               cnt_d   = 4'd0;
               abc_d   = 3'd0;
               err_d   = 4'd0;
               ffv_d   = 3'd0;
               fv_d    = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         StApply: begin
            if (sample) begin
               cnt_d = 4'd0;
               if (mismatch) begin
                  if (err_q < MaxErr) begin
                     err_d = err_q + 4'd1;
                  end
                  if (!fv_q) begin
                     fv_d  = 1'b1;
                     ffv_d = abc_q;
                  end
               end
               if (vec_q == LastVec) begin
                  state_d = StDone;
                  abc_d   = 3'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 4'd0);
               end else begin
                  vec_d = vec_q + 3'd1;
                  abc_d = vec_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            vec_d   = 3'd0;
            cnt_d   = 4'd0;
            abc_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         vec_q   <= 3'd0;
         cnt_q   <= 4'd0;
         abc_q   <= 3'd0;
         err_q   <= 4'd0;
         ffv_q   <= 3'd0;
         fv_q    <= 1'b0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         abc_q   <= abc_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         fv_q    <= fv_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign a              = abc_q[2];
   assign b              = abc_q[1];
   assign cin            = abc_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_vec = ffv_q;
   assign fail_valid     = fv_q;

endmodule

// File: tb/tb_fa_vector_checker.sv
// Directed bench: two checkers (sum+cout and sum-only) drive a behavioural
// full adder with selectable faults; results are scoreboarded per run.
module tb_fa_vector_checker;

   typedef struct {
      logic [3:0] err;
      logic [2:0] ffv;
      logic       fv;
      logic       pass;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   int   mode = 0;  // 0 good, 1 cout stuck at 0, 2 sum inverted

   logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
   logic [3:0] err1;
   logic [2:0] ffv1;
   logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
   logic [3:0] err0;
   logic [2:0] ffv0;

   int checks = 0;
   int failures = 0;
   exp_t sb1[$];
   exp_t sb0[$];

   always #5 clk = ~clk;

   assign s1  = (mode == 2) ? ~(a1 ^ b1 ^ c1) : (a1 ^ b1 ^ c1);
   assign co1 = (mode == 1) ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));
   assign s0  = (mode == 2) ? ~(a0 ^ b0 ^ c0) : (a0 ^ b0 ^ c0);
   assign co0 = (mode == 1) ? 1'b0 : ((a0 & b0) | (a0 & c0) | (b0 & c0));

   fa_vector_checker #(.SETTLE_CYCLES(2), .CHECK_COUT(1)) dut1 (
      .clk (clk), .rst (rst), .start (start),
      .a (a1), .b (b1), .cin (c1), .sum (s1), .cout (co1),
      .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
      .first_fail_vec (ffv1), .fail_valid (fv1)
   );

   fa_vector_checker #(.SETTLE_CYCLES(2), .CHECK_COUT(0)) dut0 (
      .clk (clk), .rst (rst), .start (start),
      .a (a0), .b (b0), .cin (c0), .sum (s0), .cout (co0),
      .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
      .first_fail_vec (ffv0), .fail_valid (fv0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int m, input bit cc);
      exp_t e;
      e.err = 4'd0;
      e.ffv = 3'd0;
      e.fv  = 1'b0;
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vb;
         logic va, vbb, vc, gs, gc, ds, dc;
         vb  = 3'(v);
         va  = vb[2];
         vbb = vb[1];
         vc  = vb[0];
         gs  = va ^ vbb ^ vc;
         gc  = (va & vbb) | (va & vc) | (vbb & vc);
         ds  = (m == 2) ? ~gs : gs;
         dc  = (m == 1) ? 1'b0 : gc;
         if ((ds != gs) || (cc && (dc != gc))) begin
            if (!e.fv) begin
               e.fv  = 1'b1;
               e.ffv = vb;
            end
            e.err = e.err + 4'd1;
         end
      end
      e.pass = (e.err == 4'd0);
      return e;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_abc"}, {29'd0, a1, b1, c1}, 32'd0);
      chk({tag, "_busy"}, busy1, 0);
      chk({tag, "_done"}, done1, 0);
      chk({tag, "_pass"}, pass1, 0);
      chk({tag, "_err"}, err1, 0);
      chk({tag, "_ffv"}, ffv1, 0);
      chk({tag, "_fv"}, fv1, 0);
      chk({tag, "_busy0"}, busy0, 0);
   endtask

   // One full run; start is held through APPLY when hold is set.
   task automatic run(input int m, input bit hold, input string tag);
      int   done_edge;
      exp_t e1, e0;
      mode = m;
      sb1.push_back(model(m, 1'b1));
      sb0.push_back(model(m, 1'b0));
      @(negedge clk);
      start = 1'b1;
      done_edge = -1;
      for (int k = 1; k <= 40 && done_edge < 0; k++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         if (k == 1) begin
            chk({tag, "_e1_err"}, err1, 0);
            chk({tag, "_e1_fv"}, fv1, 0);
            chk({tag, "_e1_done"}, done1, 0);
         end
         if (k <= 17) begin
            chk({tag, "_abc"}, {29'd0, a1, b1, c1}, (k < 17) ? 32'((k - 1) / 2) : 32'd0);
            chk({tag, "_busy"}, busy1, (k < 17) ? 1 : 0);
         end
         if (done1 === 1'b1) begin
            done_edge = k;
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, "_done_edge"}, done_edge, 17);
      chk({tag, "_done0"}, done0, 1);
      if (sb1.size() > 0 && sb0.size() > 0) begin
         e1 = sb1.pop_front();
         e0 = sb0.pop_front();
         chk({tag, "_err"}, err1, e1.err);
         chk({tag, "_ffv"}, e1.fv ? ffv1 : 3'd0, e1.ffv);
         chk({tag, "_fv"}, fv1, e1.fv);
         chk({tag, "_pass"}, pass1, e1.pass);
         chk({tag, "_err0"}, err0, e0.err);
         chk({tag, "_ffv0"}, e0.fv ? ffv0 : 3'd0, e0.ffv);
         chk({tag, "_pass0"}, pass0, e0.pass);
         repeat (2) @(posedge clk);
         #1;
         chk({tag, "_hold_done"}, done1, 1);
         chk({tag, "_hold_err"}, err1, e1.err);
         chk({tag, "_hold_pass"}, pass1, e1.pass);
      end else begin
         chk({tag, "_sb_empty"}, 0, 1);
      end
   endtask

   initial begin
      int found;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      run(0, 1'b0, "good");
      run(1, 1'b0, "cout0");
      run(2, 1'b0, "suminv");
      run(2, 1'b0, "suminv_again");
      run(0, 1'b1, "start_held");

      // Abort mid-run while vector 100 is applied.
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         if ({a1, b1, c1} === 3'b100) found = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("abort_reach_100", found, 1);
      chk("abort_pre_fv", fv1, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", done1, 0);
      end

      run(0, 1'b0, "post_abort");

      // Reset wins over a simultaneous start.
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      check_reset("rst_vs_start");
      start = 1'b0;
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
